rgb_pwm_driver: RTL and testbench

RGB_PWM_DRIVER -- requirements
Module: rgb_pwm_driver

---
 rtl/rgb_pwm_driver.sv | 101 ++++++++++
 tb/tb_rgb_pwm_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with a prescaled frame counter and
// double-buffered duty registers that only update on frame boundaries.
module rgb_pwm_driver #(
  parameter int PRESCALE   = 47,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty_r,
  input  logic [7:0] duty_g,
  input  logic [7:0] duty_b,
  input  logic       duty_valid,
  output logic       duty_ready,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic       period_start
);

  localparam int PRE_W = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE);

  logic [PRE_W-1:0] pre;
  logic [7:0]       cnt;
  logic             tick;
  logic             boundary;
  logic             accept;

  logic [7:0] act_r, act_g, act_b;
  logic [7:0] pend_r, pend_g, pend_b;
  logic       pend_full;

  // Pin level for one channel: lit while the frame position is below the duty.
  function automatic logic pin_level(input logic [7:0] pos, input logic [7:0] duty);
    return (pos < duty) ^ ACTIVE_LOW;
  endfunction

  assign tick       = (pre == PRE_MAX);
  assign boundary   = tick && (cnt == 8'd255);
  assign duty_ready = !pend_full;
  assign accept     = duty_valid && duty_ready;

  // Stage 0: prescaler and frame position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= 8'd0;
    end else if (tick) begin
      pre <= '0;
      cnt <= cnt + 8'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Pending buffer holds one triple; accept and transfer never coincide
  // because accept needs pend_full low and transfer needs it high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_r    <= 8'd0;
      pend_g    <= 8'd0;
      pend_b    <= 8'd0;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_r    <= duty_r;
      pend_g    <= duty_g;
      pend_b    <= duty_b;
    end else if (boundary && pend_full) begin
      pend_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_r <= 8'd0;
      act_g <= 8'd0;
      act_b <= 8'd0;
    end else if (boundary && pend_full) begin
      act_r <= pend_r;
      act_g <= pend_g;
      act_b <= pend_b;
    end
  end

  // Stage 1: registered pin drive and frame-start marker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RGB_R        <= ACTIVE_LOW;
      RGB_G        <= ACTIVE_LOW;
      RGB_B        <= ACTIVE_LOW;
      period_start <= 1'b0;
    end else begin
      RGB_R        <= pin_level(cnt, act_r);
      RGB_G        <= pin_level(cnt, act_g);
      RGB_B        <= pin_level(cnt, act_b);
      period_start <= boundary;
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver at PRESCALE=0, ACTIVE_LOW=1 (one frame = 256 clk).
// Reference model reasons in frames: a triple accepted in frame f lights frame f+1
// (f+2 if accepted in the last cycle of f); a channel is lit while pos < duty.
module tb_rgb_pwm_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] duty_r = 8'd0, duty_g = 8'd0, duty_b = 8'd0;
  logic       duty_valid = 1'b0;
  logic       duty_ready, RGB_R, RGB_G, RGB_B, period_start;

  rgb_pwm_driver #(.PRESCALE(0), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
    .duty_valid(duty_valid), .duty_ready(duty_ready),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
    .period_start(period_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: c = cycle index since reset release, act = duties lighting the
  // current frame, pnd = accepted triple waiting for frame pnd_frame.
  int c;
  int act[3];
  int pnd[3];
  bit pnd_v;
  int pnd_frame;
  logic [4:0] exp_v;  // {R, G, B, period_start, duty_ready}
  int s_pos, s_frame;
  bit s_hs;

  function automatic logic [4:0] got_v();
    return {RGB_R, RGB_G, RGB_B, period_start, duty_ready};
  endfunction

  task automatic step();
    int pos;
    bit hs;
    if (!rst_n) begin
      @(posedge clk); @(negedge clk);
      c = 0; act[0] = 0; act[1] = 0; act[2] = 0; pnd_v = 0;
      exp_v = 5'b11101;
      s_pos = -1; s_frame = -1; s_hs = 0;
      return;
    end
    pos = c % 256;
    hs  = duty_valid && !pnd_v;
    exp_v[4] = !(pos < act[0]);
    exp_v[3] = !(pos < act[1]);
    exp_v[2] = !(pos < act[2]);
    exp_v[1] = (pos == 255);
    if (hs) begin
      pnd[0] = int'(duty_r); pnd[1] = int'(duty_g); pnd[2] = int'(duty_b);
      pnd_v = 1;
      pnd_frame = c / 256 + ((pos == 255) ? 2 : 1);
    end
    s_pos = pos; s_frame = c / 256; s_hs = hs;
    @(posedge clk); @(negedge clk);
    c++;
    if (pnd_v && pnd_frame <= c / 256) begin
      act = pnd;
      pnd_v = 0;
    end
    exp_v[0] = !pnd_v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; duty_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (got_v() !== 5'b11101) begin
        errors++;
        $display("FAIL reset_hold i=%0d got=%b want=11101", i, got_v());
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      checks++;
      if (got_v() !== exp_v) begin
        errors++;
        $display("FAIL reset_idle c=%0d got=%b want=%b", c, got_v(), exp_v);
      end
    end
  endtask

  task automatic test_duty();
    int tgt;
    int lr[2], lg[2], lb[2], ps[2];
    for (int k = 0; k < 2; k++) begin lr[k] = 0; lg[k] = 0; lb[k] = 0; ps[k] = 0; end
    duty_r = 8'd64; duty_g = 8'd0; duty_b = 8'd255; duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    tgt = pnd_frame;
    for (int i = 0; i < 1200; i++) begin
      step();
      checks++;
      if (got_v() !== exp_v) begin
        errors++;
        $display("FAIL duty_cycle c=%0d got=%b want=%b", c, got_v(), exp_v);
      end
      if (s_frame > tgt + 1) break;
      if (s_frame >= tgt) begin
        lr[s_frame-tgt] += (RGB_R == 1'b0);
        lg[s_frame-tgt] += (RGB_G == 1'b0);
        lb[s_frame-tgt] += (RGB_B == 1'b0);
        ps[s_frame-tgt] += (period_start == 1'b1);
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (lr[k] != 64 || lg[k] != 0 || lb[k] != 255 || ps[k] != 1) begin
        errors++;
        $display("FAIL duty_counts frame=%0d got r=%0d g=%0d b=%0d ps=%0d want 64/0/255/1",
                 k, lr[k], lg[k], lb[k], ps[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 300 && (c % 256) != 10; i++) step();
    duty_r = 8'($urandom); duty_g = 8'($urandom); duty_b = 8'($urandom);
    duty_valid = 1'b1;
    step();
    checks++;
    if (got_v() !== exp_v) begin
      errors++;
      $display("FAIL bp_load_a c=%0d got=%b want=%b", c, got_v(), exp_v);
    end
    duty_r = 8'($urandom); duty_g = 8'($urandom); duty_b = 8'($urandom);
    s_hs = 0;
    for (int i = 0; i < 600 && !s_hs; i++) begin
      step();
      checks++;
      if (got_v() !== exp_v) begin
        errors++;
        $display("FAIL bp_hold c=%0d got=%b want=%b", c, got_v(), exp_v);
      end
    end
    duty_valid = 1'b0;
    checks++;
    if (!s_hs || s_pos != 0) begin
      errors++;
      $display("FAIL bp_capture_pos got=%0d (hs=%0d) want=0", s_pos, s_hs);
    end
    for (int i = 0; i < 600; i++) begin
      step();
      checks++;
      if (got_v() !== exp_v) begin
        errors++;
        $display("FAIL bp_after c=%0d got=%b want=%b", c, got_v(), exp_v);
      end
    end
  endtask

  task automatic test_glitch_free();
    int cur;
    int lit[2];
    lit[0] = 0; lit[1] = 0;
    duty_r = 8'd200; duty_g = 8'($urandom); duty_b = 8'($urandom); duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    for (int i = 0; i < 600 && pnd_v; i++) step();
    cur = c / 256;
    for (int i = 0; i < 800; i++) begin
      if ((c % 256) == 100 && (c / 256) == cur) begin
        duty_r = 8'd50; duty_valid = 1'b1;
      end else begin
        duty_valid = 1'b0;
      end
      step();
      checks++;
      if (got_v() !== exp_v) begin
        errors++;
        $display("FAIL glitch_cycle c=%0d got=%b want=%b", c, got_v(), exp_v);
      end
      if (s_frame > cur + 1) break;
      if (s_frame >= cur) lit[s_frame-cur] += (RGB_R == 1'b0);
    end
    duty_valid = 1'b0;
    checks++;
    if (lit[0] != 200 || lit[1] != 50) begin
      errors++;
      $display("FAIL glitch_counts got %0d/%0d want 200/50", lit[0], lit[1]);
    end
  endtask

  task automatic test_boundary_coincide();
    int f0, newr;
    int lit[2];
    lit[0] = 0; lit[1] = 0;
    for (int i = 0; i < 300 && (c % 256) != 255; i++) step();
    newr = 100 + int'($urandom_range(0, 149));
    duty_r = 8'(newr); duty_g = 8'($urandom); duty_b = 8'($urandom); duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    f0 = s_frame;
    for (int i = 0; i < 900; i++) begin
      step();
      checks++;
      if (got_v() !== exp_v) begin
        errors++;
        $display("FAIL coincide_cycle c=%0d got=%b want=%b", c, got_v(), exp_v);
      end
      if (s_frame > f0 + 2) break;
      if (s_frame > f0) lit[s_frame-f0-1] += (RGB_R == 1'b0);
    end
    checks++;
    if (lit[0] != 50 || lit[1] != newr) begin
      errors++;
      $display("FAIL coincide_counts got %0d/%0d want 50/%0d", lit[0], lit[1], newr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      duty_valid = ($urandom_range(0, 7) == 0);
      duty_r = 8'($urandom); duty_g = 8'($urandom); duty_b = 8'($urandom);
      step();
      checks++;
      if (got_v() !== exp_v) begin
        errors++;
        $display("FAIL random c=%0d got=%b want=%b", c, got_v(), exp_v);
      end
    end
    duty_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lit;
    lit = 0;
    duty_r = 8'd128; duty_g = 8'd128; duty_b = 8'd128; duty_valid = 1'b1;
    for (int i = 0; i < 300 && !s_hs; i++) step();
    duty_valid = 1'b0;
    for (int i = 0; i < 600 && pnd_v; i++) step();
    for (int i = 0; i < 300 && (c % 256) != 20; i++) step();
    duty_r = 8'($urandom); duty_valid = 1'b1;
    step();
    duty_valid = 1'b0;
    for (int i = 0; i < 300 && (c % 256) != 150; i++) step();
    checks++;
    if (duty_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pending got ready=%b want 0", duty_ready);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (got_v() !== 5'b11101) begin
      errors++;
      $display("FAIL rstmid_assert got=%b want=11101", got_v());
    end
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      lit += (RGB_R == 1'b0) + (RGB_G == 1'b0) + (RGB_B == 1'b0);
      checks++;
      if (got_v() !== exp_v) begin
        errors++;
        $display("FAIL rstmid_after c=%0d got=%b want=%b", c, got_v(), exp_v);
      end
    end
    checks++;
    if (lit != 0) begin
      errors++;
      $display("FAIL rstmid_lit got=%0d want=0", lit);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_duty();
    test_backpressure();
    test_glitch_free();
    test_boundary_coincide();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
